uart_tx_sched: RTL and testbench
================================

// Module: uart_tx_sched
// PURPOSE
//  Transmit-side controller for the UART: drains bytes from the synchronous TX FIFO and serialises each one as an 8N1 frame on tx_o.
//  Sits between the FIFO and the pad, pops exactly one entry per frame and paces bits with a programmable baud divider.
//  Reports busy and per-frame completion status to the UART register block.
// PARAMETERS
//  DATAW  8   data bits per frame, LSB first
//  DIVW   16  width of baud divisor
// PORTS
//  clk_i         in   1      system clock; all logic on posedge
//  rst_ni        in   1      synchronous reset, active-low
//  en_i          in   1      transmitter enable; gates frame start only
//  div_i         in   DIVW   bit period = div_i+1 clk cycles
//  par_odd_i     in   1      1=odd, 0=even parity; used only with UART_TX_PARITY_EN
//  fifo_empty_i  in   1      TX FIFO empty flag
//  fifo_dat_i    in   DATAW  TX FIFO head entry; combinational, valid while !fifo_empty_i
//  fifo_re_o     out  1      pop strobe to TX FIFO; at most 1 cycle per frame
//  tx_o          out  1      serial line; idle high
//  busy_o        out  1      frame in progress (state != IDLE)
//  done_o        out  1      1-cycle pulse on the last cycle of STOP
// BEHAVIOUR
//  - Reset (rst_ni=0 at posedge): state=IDLE, tx_o=1, busy_o=0, done_o=0, baud/bit counters=0; fifo_re_o=0 while reset is asserted.
//  - Reset mid-frame aborts at once: line returns high next cycle. The popped byte is lost, with no FIFO rewind.
//  - fifo_re_o = (state==IDLE) & en_i & !fifo_empty_i & rst_ni; this is the only combinational output.
//  - IDLE: when fifo_re_o=1, the same edge does three things:
//      latch fifo_dat_i into the shift register;
//      latch div_i into the divisor register;
//      go to START.
//  - Each later state holds for exactly div_i+1 cycles, tracked by a baud counter reloaded at every state/bit change.
//  - div_i changes mid-frame have no effect; the latched copy is used. div_i=0 gives 1 cycle per bit.
//  - START: tx_o=0. DATA: DATAW bits, LSB first, with the shift register shifted right per bit period; the bit index counts 0..DATAW-1.
//  - DATA -> STOP, or DATA -> PARITY when the feature is compiled in. STOP: tx_o=1; done_o=1 on its final cycle; then -> IDLE.
//  - Frame-to-frame gap: one IDLE cycle minimum, so back-to-back frames are (DATAW+2)*(div_i+1)+1 cycles apart, (DATAW+3)*(div_i+1)+1 with parity.
//  - tx_o is registered and changes on the edge that enters each state or bit, so tx_o lags fifo_re_o by 1 cycle.
//  - en_i dropped mid-frame: the current frame completes, and no further pop occurs.
//  - FIFO empty in IDLE: no pop, and tx_o stays 1 indefinitely.
//  - fifo_re_o is never asserted while fifo_empty_i=1, so the FIFO underflow guard is never relied upon.
// CONFIGURATION
//  UART_TX_PARITY_EN defined:
//    PARITY state inserted after DATA for one bit period.
//    tx_o = ^data ^ par_odd_i, computed on the byte latched at frame start.
//  Not defined:
//    DATA -> STOP directly; par_odd_i is ignored (port remains for a stable interface).
// STRUCTURE
//  - Package uart_pkg holds:
//      state encodings (IDLE/START/DATA/PARITY/STOP, 3-bit);
//      UART_IDLE_LVL=1'b1;
//      default DATAW/DIVW constants shared with the RX side.
//  - Sub-module uart_baud_cnt(DIVW):
//      inputs: load, div;
//      output: tick on terminal count;
//      reused by the RX controller.
//  - The FSM, shift register and bit counter live in uart_tx_sched.
// TESTING
//  1. Reset: hold rst_ni=0 for 3 cycles with FIFO non-empty -> tx_o=1, fifo_re_o=0, busy_o=0 throughout; first pop on the cycle after release.
//  2. Single byte 0xA5, div_i=3 -> line reads start 0 then bits 1,0,1,0,0,1,0,1 then stop 1, each held 4 cycles; done_o pulses once; exactly one pop.
//  3. Back-to-back 0x00 then 0xFF, div_i=0 -> second START begins 11 cycles after first START; 2 pops total; busy_o low exactly 1 cycle between frames.
//  4. en_i=0 at cycle 5 of a frame with 2 entries queued -> first frame completes, no second pop, tx_o stays 1.
//  5. Parity build, 0x07, par_odd_i=0 -> parity bit 1; with par_odd_i=1 -> 0; non-parity build: frame length 10 bit periods.
//  6. rst_ni pulsed low during DATA bit 3 -> tx_o=1 next cycle, state IDLE, done_o never pulses for that frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the TX and RX controllers.
//   uart_state_e  : 3-bit frame state encoding (IDLE/START/DATA/PARITY/STOP)
//   UART_IDLE_LVL : logic level of the idle serial line
//   UART_DATAW    : default data bits per frame
//   UART_DIVW     : default baud divisor width
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic UART_IDLE_LVL = 1'b1;
  localparam int   UART_DATAW    = 8;
  localparam int   UART_DIVW     = 16;

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud period counter shared by the UART TX and RX controllers.
// A load reloads the counter with div; it then counts down to zero and
// holds there. tick is high while the count is zero, so a period started
// by a load lasts div+1 cycles, the last of which has tick=1.
// Ports:
//   clk_i  in  1     system clock
//   rst_ni in  1     synchronous reset, active-low (count -> 0)
//   load   in  1     reload the counter from div
//   div    in  DIVW  period length minus one
//   tick   out 1     terminal count reached
module uart_baud_cnt #(
  parameter int DIVW = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load,
  input  logic [DIVW-1:0] div,
  output logic            tick
);

  logic [DIVW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= div;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_sched.sv
// UART transmit scheduler: pops one byte per frame from the TX FIFO and
// serialises it as an 8N1 frame (start, DATAW bits LSB first, stop).
// Optional macro UART_TX_PARITY_EN inserts a parity bit after the data
// bits (parity = ^data ^ par_odd_i, fixed at frame start).
// Ports:
//   clk_i        in  1      system clock
//   rst_ni       in  1      synchronous reset, active-low
//   en_i         in  1      transmitter enable, gates frame start only
//   div_i        in  DIVW   bit period = div_i+1 cycles, latched per frame
//   par_odd_i    in  1      1=odd, 0=even parity (parity build only)
//   fifo_empty_i in  1      TX FIFO empty flag
//   fifo_dat_i   in  DATAW  TX FIFO head entry
//   fifo_re_o    out 1      FIFO pop strobe (combinational)
//   tx_o         out 1      serial line, idle high
//   busy_o       out 1      frame in progress
//   done_o       out 1      pulse on the final cycle of STOP
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int DATAW = UART_DATAW,
  parameter int DIVW  = UART_DIVW
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [DIVW-1:0]  div_i,
  input  logic             par_odd_i,
  input  logic             fifo_empty_i,
  input  logic [DATAW-1:0] fifo_dat_i,
  output logic             fifo_re_o,
  output logic             tx_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int BITW = (DATAW > 1) ? $clog2(DATAW) : 1;
  localparam logic [BITW-1:0] LAST_BIT = BITW'(DATAW - 1);

  uart_state_e      state_q, state_d;
  logic [BITW-1:0]  bit_q, bit_d;
  logic             tx_q, tx_d;
  logic [DATAW-1:0] shreg_q;
  logic [DIVW-1:0]  div_q;
  logic [DIVW-1:0]  baud_div;
  logic             baud_load;
  logic             baud_tick;
  logic             shift_en;

`ifdef UART_TX_PARITY_EN
  logic par_q;

  function automatic logic calc_parity(input logic [DATAW-1:0] data,
                                       input logic             odd);
    return (^data) ^ odd;
  endfunction
`else
  logic unused_par_odd;
  assign unused_par_odd = par_odd_i;
`endif

  assign fifo_re_o = (state_q == ST_IDLE) & en_i & ~fifo_empty_i & rst_ni;

  // The START period is loaded while the divisor register is still being
  // written, so it takes div_i directly; every later period uses the copy.
  assign baud_div = (state_q == ST_IDLE) ? div_i : div_q;

  uart_baud_cnt #(
    .DIVW (DIVW)
  ) u_baud (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load   (baud_load),
    .div    (baud_div),
    .tick   (baud_tick)
  );

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    baud_load = 1'b0;
    shift_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = UART_IDLE_LVL;
        if (fifo_re_o) begin
          state_d   = ST_START;
          tx_d      = 1'b0;
          baud_load = 1'b1;
        end
      end
      ST_START: begin
        if (baud_tick) begin
          state_d   = ST_DATA;
          bit_d     = '0;
          tx_d      = shreg_q[0];
          baud_load = 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          baud_load = 1'b1;
          if (bit_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = par_q;
`else
            state_d = ST_STOP;
            tx_d    = UART_IDLE_LVL;
`endif
          end else begin
            bit_d    = bit_q + 1'b1;
            shift_en = 1'b1;
            // Next bit is the one that moves into position 0 this edge.
            tx_d     = shreg_q[1];
          end
        end
      end
      ST_PARITY: begin
`ifdef UART_TX_PARITY_EN
        if (baud_tick) begin
          state_d   = ST_STOP;
          tx_d      = UART_IDLE_LVL;
          baud_load = 1'b1;
        end
`else
        state_d = ST_IDLE;
        tx_d    = UART_IDLE_LVL;
`endif
      end
      ST_STOP: begin
        if (baud_tick) begin
          state_d = ST_IDLE;
          tx_d    = UART_IDLE_LVL;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = UART_IDLE_LVL;
      end
    endcase
  end

  // Control registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      bit_q   <= '0;
      tx_q    <= UART_IDLE_LVL;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  // Frame data registers, written only on a pop or a bit advance
  always_ff @(posedge clk_i) begin
    if (fifo_re_o) begin
      shreg_q <= fifo_dat_i;
      div_q   <= div_i;
    end else if (shift_en) begin
      shreg_q <= shreg_q >> 1;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk_i) begin
    if (fifo_re_o) begin
      par_q <= calc_parity(fifo_dat_i, par_odd_i);
    end
  end
`endif

  assign tx_o   = tx_q;
  assign busy_o = (state_q != ST_IDLE);
  assign done_o = (state_q == ST_STOP) & baud_tick;

endmodule

// File: tb/tb_uart_tx_sched.sv
module tb_uart_tx_sched;

`ifdef UART_TX_PARITY_EN
  localparam int FLEN    = 11;
  localparam bit HAS_PAR = 1'b1;
`else
  localparam int FLEN    = 10;
  localparam bit HAS_PAR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] div;
  logic        par_odd;
  logic        fifo_empty;
  logic [7:0]  fifo_dat;
  logic        fifo_re;
  logic        tx;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  uart_tx_sched dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .en_i         (en),
    .div_i        (div),
    .par_odd_i    (par_odd),
    .fifo_empty_i (fifo_empty),
    .fifo_dat_i   (fifo_dat),
    .fifo_re_o    (fifo_re),
    .tx_o         (tx),
    .busy_o       (busy),
    .done_o       (done)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [7:0] q[$];

  // Reference frame model: frame active flag plus cycle offset into it.
  bit         fr_act = 1'b0;
  int         fr_off = 0;
  logic [7:0] fr_byte;
  int         fr_div = 0;
  logic       fr_par;
  bit         pend = 1'b0;
  logic [7:0] pend_byte;
  int         pend_div;
  logic       pend_par;

  int   pop_cnt = 0, done_cnt = 0, last_pop = 0, prev_pop = 0;
  int   low_run = 0, last_gap = 0, hi_run = 0, last_hi = 0;
  logic par_seen;

  int base_pop, base_done;
  bit reached;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic exp_bit(input int idx, input logic [7:0] b, input logic p);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (HAS_PAR && idx == 9) return p;
    return 1'b1;
  endfunction

  // One clock cycle: present FIFO head, check outputs, then advance model.
  task automatic step();
    logic exp_re, exp_tx, exp_busy, exp_done;
    fifo_empty = (q.size() == 0);
    fifo_dat   = fifo_empty ? 8'($urandom) : q[0];
    #1;
    exp_re   = rst_n && en && !fifo_empty && !fr_act;
    exp_busy = fr_act;
    exp_tx   = fr_act ? exp_bit(fr_off / (fr_div + 1), fr_byte, fr_par) : 1'b1;
    exp_done = fr_act && (fr_off == FLEN * (fr_div + 1) - 1);
    chk("fifo_re", fifo_re, exp_re);
    chk("tx", tx, exp_tx);
    chk("busy", busy, exp_busy);
    chk("done", done, exp_done);
    if (fr_act && fr_off == 9 * (fr_div + 1)) par_seen = tx;
    if (!busy) low_run++;
    if (fifo_re) begin
      pop_cnt++;
      prev_pop = last_pop;
      last_pop = cyc;
      last_gap = low_run;
      low_run  = 0;
      if (q.size() > 0) void'(q.pop_front());
    end
    if (busy) hi_run++;
    else if (hi_run != 0) begin
      last_hi = hi_run;
      hi_run  = 0;
    end
    if (done) done_cnt++;
    pend      = exp_re;
    pend_byte = fifo_dat;
    pend_div  = int'(div);
    pend_par  = (^fifo_dat) ^ par_odd;
    @(posedge clk);
    cyc++;
    if (!rst_n) fr_act = 1'b0;
    else if (pend) begin
      fr_act  = 1'b1;
      fr_off  = 0;
      fr_byte = pend_byte;
      fr_div  = pend_div;
      fr_par  = pend_par;
    end else if (fr_act) begin
      fr_off++;
      if (fr_off == FLEN * (fr_div + 1)) fr_act = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic run_idle();
    int n;
    n = 0;
    while ((fr_act || pend || q.size() > 0) && n < 4000) begin
      step();
      n++;
    end
    if (n >= 4000) begin
      fails++;
      $error("FAIL run_idle_timeout: observed %0d cycles expected < 4000", n);
    end
    step();
    step();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    en         = 1'b1;
    div        = 16'd3;
    par_odd    = 1'b0;
    fifo_empty = 1'b1;
    fifo_dat   = 8'h00;
    q.push_back(8'h3C);
    @(posedge clk);
    @(negedge clk);

    // Reset held with FIFO non-empty
    repeat (3) step();
    chk("rst_no_pop", pop_cnt, 0);
    rst_n = 1'b1;
    step();
    chk("pop_after_release", pop_cnt, 1);
    run_idle();

    // Single byte 0xA5, div 3
    div       = 16'd3;
    base_pop  = pop_cnt;
    base_done = done_cnt;
    q.push_back(8'hA5);
    run_idle();
    chk("a5_pops", pop_cnt - base_pop, 1);
    chk("a5_done", done_cnt - base_done, 1);
    chk("a5_len", last_hi, FLEN * 4);

    // Back-to-back 0x00, 0xFF at div 0
    div       = 16'd0;
    base_pop  = pop_cnt;
    q.push_back(8'h00);
    q.push_back(8'hFF);
    run_idle();
    chk("b2b_pops", pop_cnt - base_pop, 2);
    chk("b2b_spacing", last_pop - prev_pop, FLEN + 1);
    chk("b2b_gap", last_gap, 1);
    chk("b2b_len", last_hi, FLEN);

    // Enable dropped mid-frame with two entries queued
    div       = 16'd2;
    base_pop  = pop_cnt;
    base_done = done_cnt;
    q.push_back(8'h5A);
    q.push_back(8'hC3);
    step();
    repeat (5) step();
    en = 1'b0;
    repeat (FLEN * 3 * 3) step();
    chk("en_pops", pop_cnt - base_pop, 1);
    chk("en_done", done_cnt - base_done, 1);
    chk("en_q_left", q.size(), 1);
    chk("en_tx_idle", tx, 1'b1);
    q.delete();
    en = 1'b1;
    step();

    // Parity: 0x07 even then odd
    div     = 16'd1;
    par_odd = 1'b0;
    q.push_back(8'h07);
    run_idle();
`ifdef UART_TX_PARITY_EN
    chk("par_even", par_seen, 1'b1);
`else
    chk("len_nopar", last_hi, 20);
`endif
    par_odd = 1'b1;
    q.push_back(8'h07);
    run_idle();
`ifdef UART_TX_PARITY_EN
    chk("par_odd", par_seen, 1'b0);
`else
    chk("len_nopar2", last_hi, 20);
`endif

    // Random bytes, divisor and parity sense changing every cycle
    base_pop  = pop_cnt;
    base_done = done_cnt;
    for (int f = 0; f < 24; f++) q.push_back(8'($urandom));
    for (int i = 0; i < 4000 && (q.size() > 0 || fr_act || pend); i++) begin
      div     = 16'($urandom_range(0, 3));
      par_odd = 1'($urandom);
      step();
    end
    run_idle();
    chk("rand_pops", pop_cnt - base_pop, 24);
    chk("rand_done", done_cnt - base_done, 24);

    // Reset pulse during DATA bit 3
    div       = 16'd2;
    base_done = done_cnt;
    q.push_back(8'h96);
    reached = 1'b0;
    for (int i = 0; i < 100 && !reached; i++) begin
      step();
      reached = fr_act && (fr_off == 4 * 3);
    end
    if (!reached) begin
      fails++;
      $error("FAIL rst_mid_reach: observed not reached expected DATA bit 3");
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (40) step();
    chk("rst_abort_done", done_cnt - base_done, 0);
    chk("rst_abort_tx", tx, 1'b1);
    chk("rst_abort_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
